// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads one word per controller request
// through a single-outstanding request/valid handshake with instruction memory.
module instr_fetch #(
    parameter logic [31:0] ResetVector = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        res,
    input  logic        instr_req,
    output logic        instr_valid,
    output logic [31:0] instr_read,
    output logic [31:0] pc,
    input  logic        pc_enable,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    output logic        fetch_error,
    output logic [31:0] retired
);

    typedef logic [31:0] instr_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    instr_t      instr_q, instr_d;
    logic        error_q, error_d;
    logic [31:0] retired_q, retired_d;

    always_ff @(posedge clk) begin
        if (res) begin
            state_q   <= IDLE;
            pc_q      <= ResetVector;
            instr_q   <= '0;
            error_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            error_q   <= error_d;
            retired_q <= retired_d;
        end
    end

    // A PC update in IDLE wins over a simultaneous request, so the fetch that
    // follows always sees the new PC.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        error_d   = error_q;
        retired_d = retired_q;
        unique case (state_q)
            IDLE: begin
                if (pc_enable) begin
                    pc_d      = branch_taken ? branch_target : pc_q + 32'd4;
                    retired_d = retired_q + 32'd1;
                end else if (instr_req) begin
                    if (pc_q[1:0] == 2'b00) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase
    end

    assign imem_req    = (state_q == ISSUE);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == DONE);
    assign instr_read  = instr_q;
    assign pc          = pc_q;
    assign fetch_error = error_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; memory responses are driven
// by hand at the cycle each step calls for.
module tb_instr_fetch;

    logic        clk;
    logic        res;
    logic        instr_req;
    logic        instr_valid;
    logic [31:0] instr_read;
    logic [31:0] pc;
    logic        pc_enable;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic        fetch_error;
    logic [31:0] retired;

    int compared   = 0;
    int mismatched = 0;

    instr_fetch #(.ResetVector(32'h0000_0000)) dut (
        .clk          (clk),
        .res          (res),
        .instr_req    (instr_req),
        .instr_valid  (instr_valid),
        .instr_read   (instr_read),
        .pc           (pc),
        .pc_enable    (pc_enable),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_rvalid  (imem_rvalid),
        .fetch_error  (fetch_error),
        .retired      (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one edge and settle just after it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        res = 1'b1; instr_req = 1'b0; pc_enable = 1'b0; branch_taken = 1'b0;
        branch_target = '0; imem_rdata = '0; imem_rvalid = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("rst_pc", pc, 32'h0);
        checkOutput("rst_valid", {31'b0, instr_valid}, 32'h0);
        checkOutput("rst_imem_req", {31'b0, imem_req}, 32'h0);
        checkOutput("rst_imem_addr", imem_addr, 32'h0);
        checkOutput("rst_instr_read", instr_read, 32'h0);
        checkOutput("rst_fetch_error", {31'b0, fetch_error}, 32'h0);
        checkOutput("rst_retired", retired, 32'h0);

        // Basic fetch, latency 1
        res = 1'b0; instr_req = 1'b1;
        applyStimulus();
        checkOutput("f1_issue_req", {31'b0, imem_req}, 32'h1);
        checkOutput("f1_issue_addr", imem_addr, 32'h0);
        checkOutput("f1_issue_valid", {31'b0, instr_valid}, 32'h0);
        instr_req = 1'b0;
        applyStimulus();
        checkOutput("f1_wait_req", {31'b0, imem_req}, 32'h0);
        imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        applyStimulus();
        imem_rvalid = 1'b0;
        checkOutput("f1_done_valid", {31'b0, instr_valid}, 32'h1);
        checkOutput("f1_done_read", instr_read, 32'h0050_0093);
        applyStimulus();
        checkOutput("f1_after_valid", {31'b0, instr_valid}, 32'h0);

        // Sequential and taken PC updates
        pc_enable = 1'b1; branch_taken = 1'b0;
        applyStimulus();
        checkOutput("seq_pc", pc, 32'h4);
        checkOutput("seq_retired", retired, 32'h1);
        branch_taken = 1'b1; branch_target = 32'h40;
        applyStimulus();
        checkOutput("br_pc", pc, 32'h40);
        checkOutput("br_retired", retired, 32'h2);

        // pc_enable together with instr_req: update first, fetch deferred
        branch_taken = 1'b0; instr_req = 1'b1;
        applyStimulus();
        checkOutput("defer_pc", pc, 32'h44);
        checkOutput("defer_no_req", {31'b0, imem_req}, 32'h0);
        pc_enable = 1'b0;
        applyStimulus();
        checkOutput("f2_issue_req", {31'b0, imem_req}, 32'h1);
        checkOutput("f2_issue_addr", imem_addr, 32'h44);

        // Latency 5 with a spurious response in the ISSUE cycle
        instr_req = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus();
            imem_rvalid = 1'b0;
            checkOutput($sformatf("f2_wait%0d_valid", i), {31'b0, instr_valid}, 32'h0);
            checkOutput($sformatf("f2_wait%0d_read", i), instr_read, 32'h0050_0093);
        end
        applyStimulus();
        checkOutput("f2_k5_valid", {31'b0, instr_valid}, 32'h0);
        imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        applyStimulus();
        imem_rvalid = 1'b0;
        checkOutput("f2_done_valid", {31'b0, instr_valid}, 32'h1);
        checkOutput("f2_done_read", instr_read, 32'h1234_5678);
        applyStimulus();
        checkOutput("f2_after_valid", {31'b0, instr_valid}, 32'h0);
        checkOutput("f2_after_req", {31'b0, imem_req}, 32'h0);

        // Misaligned branch target, then a fetch attempt
        pc_enable = 1'b1; branch_taken = 1'b1; branch_target = 32'h42;
        applyStimulus();
        checkOutput("mis_pc", pc, 32'h42);
        checkOutput("mis_retired", retired, 32'h4);
        pc_enable = 1'b0; branch_taken = 1'b0; instr_req = 1'b1;
        applyStimulus();
        checkOutput("mis_error", {31'b0, fetch_error}, 32'h1);
        for (int i = 0; i < 20; i++) begin
            checkOutput($sformatf("err%0d_req", i), {31'b0, imem_req}, 32'h0);
            checkOutput($sformatf("err%0d_valid", i), {31'b0, instr_valid}, 32'h0);
            applyStimulus();
        end
        checkOutput("err_sticky", {31'b0, fetch_error}, 32'h1);
        res = 1'b1;
        applyStimulus();
        res = 1'b0; instr_req = 1'b0;
        checkOutput("err_rst_error", {31'b0, fetch_error}, 32'h0);
        checkOutput("err_rst_pc", pc, 32'h0);
        checkOutput("err_rst_retired", retired, 32'h0);

        // Reset during WAIT, with pc_enable ignored while waiting
        instr_req = 1'b1;
        applyStimulus();
        instr_req = 1'b0;
        applyStimulus();
        pc_enable = 1'b1;
        applyStimulus();
        pc_enable = 1'b0;
        checkOutput("wait_pcen_pc", pc, 32'h0);
        checkOutput("wait_pcen_retired", retired, 32'h0);
        res = 1'b1;
        applyStimulus();
        res = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_5555;
        applyStimulus();
        imem_rvalid = 1'b0;
        checkOutput("late_valid0", {31'b0, instr_valid}, 32'h0);
        applyStimulus();
        checkOutput("late_valid1", {31'b0, instr_valid}, 32'h0);
        checkOutput("late_read", instr_read, 32'h0);
        checkOutput("late_pc", pc, 32'h0);

        // Normal fetch after the mid-fetch reset
        instr_req = 1'b1;
        applyStimulus();
        instr_req = 1'b0;
        checkOutput("f3_issue_req", {31'b0, imem_req}, 32'h1);
        checkOutput("f3_issue_addr", imem_addr, 32'h0);
        applyStimulus();
        imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113;
        applyStimulus();
        imem_rvalid = 1'b0;
        checkOutput("f3_done_valid", {31'b0, instr_valid}, 32'h1);
        checkOutput("f3_done_read", instr_read, 32'h00A0_0113);
        applyStimulus();

        // PC wrap at the top of the address space
        pc_enable = 1'b1; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        applyStimulus();
        checkOutput("wrap_top_pc", pc, 32'hFFFF_FFFC);
        branch_taken = 1'b0;
        applyStimulus();
        pc_enable = 1'b0;
        checkOutput("wrap_pc", pc, 32'h0);
        checkOutput("wrap_retired", retired, 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
